instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL provide the following parameters (name, default, meaning):
  RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
  NOP_INSTR, 32'h0000_0013, instruction driven on if_instr when if_valid=0 (addi x0,x0,0).
REQ-003 The block SHALL provide the following ports (name, direction, width, meaning):
  clk             in   1   rising-edge clock
  rst_n           in   1   asynchronous active-low reset
  imem_req_valid  out  1   fetch request valid
  imem_req_ready  in   1   memory accepts request
  imem_req_addr   out  32  fetch address, word aligned
  imem_rsp_valid  in   1   response valid; in order, one per accepted request, at least 1 cycle after acceptance, no backpressure
  imem_rsp_data   in   32  fetched instruction
  redirect_valid  in   1   taken branch, JAL or JALR resolved downstream
  redirect_pc     in   32  redirect target
  if_valid        out  1   instruction available to decode
  if_ready        in   1   decode consumes instruction
  if_instr        out  32  head instruction
  if_pc           out  32  PC of head instruction
  if_opcode       out  7   if_instr[6:0], feeds the decode control unit opcode input

Function
REQ-004 The block SHALL hold a 2-entry in-order instruction buffer; {if_instr, if_pc} SHALL show the head entry, or {NOP_INSTR, 0} when the buffer is empty.
REQ-005 if_valid SHALL equal "buffer not empty"; a pop SHALL occur on if_valid & if_ready.
REQ-006 The block SHALL maintain an outstanding counter (0..2) of accepted requests without responses, and SHALL assert a new request only when the registered outstanding count plus the registered buffer count is < 2.
REQ-007 Once asserted, imem_req_valid and imem_req_addr SHALL remain stable until imem_req_ready=1, including across redirects.
REQ-008 On each accepted request the fetch PC SHALL advance by 4, wrapping modulo 2^32.
REQ-009 A non-stale response SHALL be written into the buffer at the next clock edge and SHALL be visible on if_valid in the following cycle; a push and a pop in the same cycle SHALL both take effect.
REQ-010 The FSM SHALL have states BOOT, RUN and DRAIN: BOOT->RUN after one cycle; requests SHALL be issued only in RUN (or held per REQ-007).
REQ-011 On redirect_valid the block SHALL flush all buffer entries regardless of if_ready, load the fetch PC with {redirect_pc[31:2],2'b00}, and mark every outstanding request, including one accepted that same cycle, as stale.
REQ-012 A stale response, including one arriving in the same cycle as redirect_valid, SHALL be discarded and decrement the stale count.
REQ-013 On redirect, if the stale count or a held un-accepted request is non-zero, the FSM SHALL go to DRAIN; otherwise it SHALL stay in RUN and fetch the new PC in the next cycle.
REQ-014 DRAIN SHALL exit to RUN when the stale count is 0 and no request is held; a redirect in DRAIN SHALL update the PC and stay in DRAIN.
REQ-015 A response received while outstanding=0 SHALL be ignored.

Reset
REQ-016 While rst_n=0, the following SHALL hold: state=BOOT, PC=RESET_PC, buffer empty, outstanding=0, stale=0, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_opcode=7'h13.
REQ-017 Reset asserted mid-operation SHALL abandon all in-flight requests immediately; the first request after release SHALL be RESET_PC in the second cycle after release.

Verification
REQ-018 Reset release with imem_req_ready=1, 1-cycle response latency, if_ready=1 -> addresses 0x0,0x4,0x8 issued; if_valid first high 3 cycles after release with if_pc=0x0.
REQ-019 if_ready=0 held -> at most 2 requests accepted, buffer full, imem_req_valid=0; then if_ready=1 -> instructions popped in order with PCs 0x0,0x4.
REQ-020 redirect_pc=0x103 with 2 requests outstanding -> both responses dropped, if_valid stays 0 until the fetch at 0x100 returns, FSM passes through DRAIN.
REQ-021 imem_req_ready=0 while request 0x8 is held and a redirect to 0x40 occurs -> 0x8 stays stable until accepted, its response is dropped, and the next request is 0x40.
REQ-022 Fetch PC 0xFFFF_FFFC accepted -> next request address is 0x0000_0000.
REQ-023 rst_n pulsed low with 2 requests outstanding -> all outputs at their reset values asynchronously; late responses ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests to instruction
// memory, keeps a 2-entry in-order instruction buffer for decode, and handles
// redirects by flushing the buffer and discarding responses to stale requests.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (held until accepted)
//   imem_rsp_valid/data             in-order fetch responses, no backpressure
//   redirect_valid/redirect_pc      taken branch / jump target from downstream
//   if_valid/ready/instr/pc/opcode  head instruction to decode
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode
);

    typedef enum logic [1:0] {StBoot, StRun, StDrain} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;     // PC of the next non-stale response
    logic        hold_q, hold_d;         // request presented but not yet accepted
    logic        hold_stale_q, hold_stale_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [1:0]  outst_q, outst_d;
    logic [1:0]  stale_q, stale_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];

    logic        issue_ok, accept, rsp_take, push, pop;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'h3;

    assign issue_ok       = (state_q == StRun) &&
                            (({1'b0, outst_q} + {1'b0, cnt_q}) < 3'd2);
    assign imem_req_valid = hold_q | issue_ok;
    assign imem_req_addr  = hold_q ? hold_addr_q : pc_q;
    assign accept         = imem_req_valid & imem_req_ready;

    // Responses with nothing outstanding are spurious and ignored entirely.
    assign rsp_take = imem_rsp_valid & (outst_q != 2'd0);
    // Stale requests are always the oldest, so a non-zero stale count means
    // the current response belongs to one of them.
    assign push     = rsp_take & (stale_q == 2'd0) & ~redirect_valid;
    assign pop      = (cnt_q != 2'd0) & if_ready;

    assign if_valid  = (cnt_q != 2'd0);
    assign if_instr  = if_valid ? buf_instr_q[0] : NOP_INSTR;
    assign if_pc     = if_valid ? buf_pc_q[0] : 32'h0;
    assign if_opcode = if_instr[6:0];

    always_comb begin
        hold_d       = imem_req_valid & ~imem_req_ready;
        hold_addr_d  = imem_req_addr;
        hold_stale_d = hold_d & (hold_stale_q | redirect_valid);

        outst_d = outst_q + {1'b0, accept} - {1'b0, rsp_take};

        if (redirect_valid) begin
            // Everything still in flight, including a request accepted now.
            stale_d = outst_d;
        end else begin
            stale_d = stale_q + {1'b0, accept & hold_stale_q}
                      - {1'b0, rsp_take & (stale_q != 2'd0)};
        end

        if (redirect_valid) begin
            pc_d = redirect_tgt;
        end else if (accept && !hold_stale_q) begin
            pc_d = imem_req_addr + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        if (redirect_valid) begin
            rsp_pc_d = redirect_tgt;
        end else if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end else begin
            rsp_pc_d = rsp_pc_q;
        end

        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        cnt_d       = cnt_q;
        if (pop) begin
            buf_instr_d[0] = buf_instr_q[1];
            buf_pc_d[0]    = buf_pc_q[1];
            cnt_d          = cnt_q - 2'd1;
        end
        // The issue limit guarantees at most one entry is occupied here.
        if (push) begin
            buf_instr_d[cnt_d[0]] = imem_rsp_data;
            buf_pc_d[cnt_d[0]]    = rsp_pc_q;
            cnt_d                 = cnt_d + 2'd1;
        end
        if (redirect_valid) begin
            cnt_d = 2'd0;
        end

        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (redirect_valid && ((stale_d != 2'd0) || hold_d)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!redirect_valid && (stale_d == 2'd0) && !hold_d) begin
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StBoot;
            pc_q           <= RESET_PC;
            rsp_pc_q       <= RESET_PC;
            hold_q         <= 1'b0;
            hold_stale_q   <= 1'b0;
            hold_addr_q    <= 32'h0;
            outst_q        <= 2'd0;
            stale_q        <= 2'd0;
            cnt_q          <= 2'd0;
            buf_instr_q[0] <= 32'h0;
            buf_instr_q[1] <= 32'h0;
            buf_pc_q[0]    <= 32'h0;
            buf_pc_q[1]    <= 32'h0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            rsp_pc_q       <= rsp_pc_d;
            hold_q         <= hold_d;
            hold_stale_q   <= hold_stale_d;
            hold_addr_q    <= hold_addr_d;
            outst_q        <= outst_d;
            stale_q        <= stale_d;
            cnt_q          <= cnt_d;
            buf_instr_q[0] <= buf_instr_d[0];
            buf_instr_q[1] <= buf_instr_d[1];
            buf_pc_q[0]    <= buf_pc_d[0];
            buf_pc_q[1]    <= buf_pc_d[1];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A small memory model answers each
// accepted request one cycle later with data {addr[27:0], 4'h3}.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_instr_q[$];
    bit          rsp_en;
    bit          seen_drain;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[27:0], 4'h3};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, drive memory after it.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid & imem_req_ready & rst_n;
        a   = imem_req_addr;
        if (if_valid && if_ready && !redirect_valid) begin
            pop_pc_q.push_back(if_pc);
            pop_instr_q.push_back(if_instr);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            acc_q.push_back(a);
            mem_q.push_back(a);
        end
        if (rsp_en) begin
            if (mem_q.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mdata(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
        if (logic'(dut.state_q == 2'd2)) seen_drain = 1'b1;
    endtask

    task automatic clear_logs();
        mem_q.delete();
        acc_q.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
        seen_drain = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_if_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!if_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, if_valid, 1'b1);
    endtask

    initial begin
        int idx;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;
        rsp_en         = 1'b1;
        seen_drain     = 1'b0;

        // Reset values
        #12;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_instr", if_instr, 32'h13);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_opcode", if_opcode, 7'h13);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming start-up
        step();
        check("boot_first_req", imem_req_valid, 1'b1);
        check("boot_first_addr", imem_req_addr, 32'h0);
        step();
        check("start_if_valid_early", if_valid, 1'b0);
        step();
        check("start_if_valid", if_valid, 1'b1);
        check("start_if_pc", if_pc, 32'h0);
        check("start_if_instr", if_instr, 32'h3);
        check("start_if_opcode", if_opcode, 7'h03);
        repeat (8) step();
        check("start_acc0", acc_q[0], 32'h0);
        check("start_acc1", acc_q[1], 32'h4);
        check("start_acc2", acc_q[2], 32'h8);
        check("start_pop0", pop_pc_q[0], 32'h0);
        check("start_pop1", pop_pc_q[1], 32'h4);
        check("start_pop2", pop_pc_q[2], 32'h8);
        check("start_pop3", pop_pc_q[3], 32'hC);
        check("start_pop1_instr", pop_instr_q[1], 32'h43);

        // Decode stalled: buffer fills, requests stop
        if_ready = 1'b0;
        do_reset();
        repeat (10) step();
        check("stall_nacc", acc_q.size(), 2);
        check("stall_if_valid", if_valid, 1'b1);
        check("stall_req_valid", imem_req_valid, 1'b0);
        check("stall_if_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        step();
        check("stall_pop_if_pc", if_pc, 32'h4);
        check("stall_pop_if_instr", if_instr, 32'h43);
        step();
        check("stall_pop0", pop_pc_q[0], 32'h0);
        check("stall_pop1", pop_pc_q[1], 32'h4);

        // Redirect with two requests outstanding
        do_reset();
        rsp_en = 1'b0;
        repeat (6) step();
        check("drain_nacc", acc_q.size(), 2);
        check("drain_req_idle", imem_req_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        rsp_en         = 1'b1;
        step();
        redirect_valid = 1'b0;
        wait_if_valid("drain_if_valid", 30);
        check("drain_if_pc", if_pc, 32'h100);
        check("drain_if_instr", if_instr, 32'h1003);
        check("drain_seen", seen_drain, 1'b1);
        check("drain_acc2", acc_q[2], 32'h100);

        // Redirect while a request is held by imem_req_ready=0
        do_reset();
        idx = 0;
        while (!(imem_req_valid && imem_req_addr == 32'h8) && idx < 20) begin
            step();
            idx++;
        end
        check("hold_offer_8", imem_req_addr, 32'h8);
        imem_req_ready = 1'b0;
        step();
        check("hold_valid", imem_req_valid, 1'b1);
        check("hold_addr", imem_req_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("hold_redir_valid", imem_req_valid, 1'b1);
        check("hold_redir_addr", imem_req_addr, 32'h8);
        step();
        check("hold_redir_addr2", imem_req_addr, 32'h8);
        imem_req_ready = 1'b1;
        pop_pc_q.delete();
        idx = 0;
        while (pop_pc_q.size() == 0 && idx < 30) begin
            step();
            idx++;
        end
        check("hold_first_pop", pop_pc_q[0], 32'h40);
        check("hold_acc2", acc_q[2], 32'h8);
        check("hold_acc3", acc_q[3], 32'h40);

        // Fetch PC wraps at the top of the address space
        do_reset();
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (20) step();
        idx = -1;
        for (int i = 0; i < acc_q.size() - 1; i++) begin
            if (idx < 0 && acc_q[i] == 32'hFFFF_FFFC) idx = i;
        end
        check("wrap_found", idx >= 0, 1'b1);
        if (idx >= 0) check("wrap_next", acc_q[idx + 1], 32'h0);

        // Asynchronous reset with two requests outstanding
        do_reset();
        rsp_en = 1'b0;
        repeat (6) step();
        check("areset_nacc", acc_q.size(), 2);
        check("areset_pre_addr", imem_req_addr, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_req_valid", imem_req_valid, 1'b0);
        check("areset_req_addr", imem_req_addr, 32'h0);
        check("areset_if_valid", if_valid, 1'b0);
        check("areset_if_instr", if_instr, 32'h13);
        check("areset_if_pc", if_pc, 32'h0);
        check("areset_if_opcode", if_opcode, 7'h13);
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        step();
        imem_rsp_valid = 1'b0;
        rsp_en         = 1'b1;
        wait_if_valid("areset_if_valid_after", 20);
        check("areset_restart_pc", if_pc, 32'h0);
        check("areset_restart_instr", if_instr, 32'h3);
        check("areset_acc0", acc_q[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
